cpu_run_ctrl: RTL and testbench
===============================

CPU_RUN_CTRL -- requirements
Module: cpu_run_ctrl

Interface
REQ-001 SHALL have parameter PULSE_W, default 2: system-clock cycles that clk_cpu is high, and again low, per CPU cycle (legal 1..255).
REQ-002 SHALL have port clk  input  1  system clock; single clock domain, all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port cmd_valid  input  1  command strobe.
REQ-005 SHALL have port cmd_op  input  2  command: 0 STEP, 1 RUN, 2 SETBP, 3 CLRBP.
REQ-006 SHALL have port cmd_arg  input  32  STEP count or SETBP address.
REQ-007 SHALL have port cmd_ready  output  1  command accepted when cmd_valid&&cmd_ready.
REQ-008 SHALL have port halt_req  input  1  level request to stop RUN.
REQ-009 SHALL have port pc  input  32  current CPU PC, sampled for breakpoint compare.
REQ-010 SHALL have port clk_cpu  output  1  registered CPU clock.
REQ-011 SHALL have port busy  output  1  high while pulses are being issued.
REQ-012 SHALL have port done  output  1  one-cycle pulse on return to idle after STEP/RUN.
REQ-013 SHALL have port stop_cause  output  2  0 none, 1 count, 2 breakpoint, 3 halt; held until next STEP/RUN accept.
REQ-014 SHALL have port cycle_cnt  output  32  CPU cycles issued since reset.

Function
REQ-015 SHALL implement states IDLE, HI, LO plus phase counter (0..PULSE_W-1) and 32-bit remaining counter rem.
REQ-016 cmd_ready SHALL equal (state==IDLE); commands SHALL be ignored when cmd_ready=0.
REQ-017 SETBP SHALL load bp_addr=cmd_arg and set bp_en=1; CLRBP SHALL clear bp_en; both stay in IDLE, no pulse.
REQ-018 STEP SHALL load rem=cmd_arg, with cmd_arg=0 treated as 1; RUN SHALL set run mode; both clear stop_cause to 0 and move to HI next cycle.
REQ-019 clk_cpu SHALL be 1 exactly in HI and 0 in IDLE/LO; HI and LO each last PULSE_W cycles, period 2*PULSE_W.
REQ-020 cycle_cnt SHALL increment by 1 on each IDLE/LO->HI transition, wrapping 0xFFFFFFFF->0.
REQ-021 On last LO cycle in STEP mode: rem==1 -> IDLE with stop_cause=1; else rem-=1 and -> HI.
REQ-022 On last LO cycle in RUN mode: bp_en && pc==bp_addr -> IDLE with stop_cause=2; else halt_req -> IDLE with stop_cause=3; else -> HI.
REQ-023 First pulse of RUN SHALL always be issued even if pc==bp_addr (step off breakpoint); breakpoints SHALL not stop STEP.
REQ-024 halt_req SHALL never truncate a pulse; sampled only on last LO cycle; ignored in STEP mode and IDLE.
REQ-025 done SHALL be high in the first IDLE cycle after a LO->IDLE transition only; busy = (state!=IDLE).
REQ-026 Breakpoint and halt simultaneous SHALL report stop_cause=2.

Reset
REQ-027 On rst=1 at a clock edge: state=IDLE, clk_cpu=0, busy=0, done=0, cmd_ready=1, stop_cause=0, cycle_cnt=0, rem=0, bp_en=0, bp_addr=0.
REQ-028 Reset mid-pulse SHALL force clk_cpu=0 at the next edge without completing the pulse; rst has priority over any command.

Verification
REQ-029 PULSE_W=2, STEP arg=3 -> clk_cpu 1100 x3, cycle_cnt=3, done one cycle after 12th pulse cycle, stop_cause=1.
REQ-030 STEP arg=0 -> exactly one clk_cpu pulse, stop_cause=1.
REQ-031 SETBP 0x10, pc=0x10 at RUN start, pc increments by 4 per pulse and wraps back to 0x10 after 4 pulses -> first pulse issued, stop after 4 pulses, stop_cause=2.
REQ-032 RUN, halt_req asserted mid-HI of pulse 5 -> pulse 5 completes fully, IDLE, stop_cause=3, cycle_cnt=5; commands during busy ignored.
REQ-033 rst during HI -> clk_cpu=0 next cycle, all outputs at reset values, bp_en=0 (RUN then does not stop at old bp).

Source files
------------

// File: rtl/cpu_run_ctrl.sv
// Run/step controller: issues PULSE_W-wide clk_cpu pulses for STEP/RUN commands,
// stopping on step count, breakpoint match or halt request at pulse boundaries.
module cpu_run_ctrl #(
  parameter int unsigned PULSE_W = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  input  logic [1:0]  cmd_op,
  input  logic [31:0] cmd_arg,
  output logic        cmd_ready,
  input  logic        halt_req,
  input  logic [31:0] pc,
  output logic        clk_cpu,
  output logic        busy,
  output logic        done,
  output logic [1:0]  stop_cause,
  output logic [31:0] cycle_cnt
);

  typedef enum logic [1:0] {S_IDLE, S_HI, S_LO} state_e;
  typedef enum logic [1:0] {OP_STEP, OP_RUN, OP_SETBP, OP_CLRBP} op_e;
  typedef enum logic [1:0] {SC_NONE, SC_COUNT, SC_BP, SC_HALT} cause_e;

  localparam logic [7:0] PHASE_LAST = 8'(PULSE_W - 1);

  state_e      state_q, state_d;
  logic [7:0]  phase_q, phase_d;
  logic [31:0] rem_q, rem_d;
  logic        run_q, run_d;
  logic        bp_en_q, bp_en_d;
  logic [31:0] bp_addr_q, bp_addr_d;
  cause_e      cause_q, cause_d;
  logic [31:0] cnt_q, cnt_d;
  logic        done_q, done_d;
  logic        clk_cpu_q, clk_cpu_d;
  logic        last_phase;

  assign last_phase = (phase_q == PHASE_LAST);

  // NOTE: every signal gets a default first, so no path through the case can infer a latch.
  always_comb begin
    state_d   = state_q;
    phase_d   = phase_q;
    rem_d     = rem_q;
    run_d     = run_q;
    bp_en_d   = bp_en_q;
    bp_addr_d = bp_addr_q;
    cause_d   = cause_q;
    cnt_d     = cnt_q;

    unique case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          unique case (op_e'(cmd_op))
            OP_STEP: begin
              rem_d   = (cmd_arg == 32'd0) ? 32'd1 : cmd_arg;
              run_d   = 1'b0;
              cause_d = SC_NONE;
              state_d = S_HI;
              phase_d = 8'd0;
              cnt_d   = cnt_q + 32'd1;
            end
            OP_RUN: begin
              run_d   = 1'b1;
              cause_d = SC_NONE;
              state_d = S_HI;
              phase_d = 8'd0;
              cnt_d   = cnt_q + 32'd1;
            end
            OP_SETBP: begin
              bp_addr_d = cmd_arg;
              bp_en_d   = 1'b1;
            end
            OP_CLRBP: bp_en_d = 1'b0;
          endcase
        end
      end
      S_HI: begin
        if (last_phase) begin
          state_d = S_LO;
          phase_d = 8'd0;
        end else begin
          phase_d = phase_q + 8'd1;
        end
      end
      S_LO: begin
        if (!last_phase) begin
          phase_d = phase_q + 8'd1;
        end else begin
          // Stop conditions are judged only here, so a pulse is never cut short.
          phase_d = 8'd0;
          if (run_q) begin
            if (bp_en_q && (pc == bp_addr_q)) begin
              state_d = S_IDLE;
              cause_d = SC_BP;
            end else if (halt_req) begin
              state_d = S_IDLE;
              cause_d = SC_HALT;
            end else begin
              state_d = S_HI;
              cnt_d   = cnt_q + 32'd1;
            end
          end else if (rem_q == 32'd1) begin
            state_d = S_IDLE;
            cause_d = SC_COUNT;
          end else begin
            rem_d   = rem_q - 32'd1;
            state_d = S_HI;
            cnt_d   = cnt_q + 32'd1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    done_d    = (state_q == S_LO) && (state_d == S_IDLE);
    clk_cpu_d = (state_d == S_HI);
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      phase_q   <= 8'd0;
      rem_q     <= 32'd0;
      run_q     <= 1'b0;
      bp_en_q   <= 1'b0;
      bp_addr_q <= 32'd0;
      cause_q   <= SC_NONE;
      cnt_q     <= 32'd0;
      done_q    <= 1'b0;
      clk_cpu_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      phase_q   <= phase_d;
      rem_q     <= rem_d;
      run_q     <= run_d;
      bp_en_q   <= bp_en_d;
      bp_addr_q <= bp_addr_d;
      cause_q   <= cause_d;
      cnt_q     <= cnt_d;
      done_q    <= done_d;
      clk_cpu_q <= clk_cpu_d;
    end
  end

  assign cmd_ready  = (state_q == S_IDLE);
  assign busy       = (state_q != S_IDLE);
  assign done       = done_q;
  assign clk_cpu    = clk_cpu_q;
  assign stop_cause = cause_q;
  assign cycle_cnt  = cnt_q;

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Directed bench for cpu_run_ctrl (PULSE_W=2): step counts, breakpoints,
// halt at pulse boundaries, ignored commands while busy and mid-pulse reset.
module tb_cpu_run_ctrl;

  localparam logic [1:0] OP_STEP = 2'd0, OP_RUN = 2'd1, OP_SETBP = 2'd2, OP_CLRBP = 2'd3;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid;
  logic [1:0]  cmd_op;
  logic [31:0] cmd_arg;
  logic        cmd_ready;
  logic        halt_req;
  logic [31:0] pc;
  logic        clk_cpu;
  logic        busy;
  logic        done;
  logic [1:0]  stop_cause;
  logic [31:0] cycle_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  int          pulses, hi_n;
  logic [31:0] pat;

  cpu_run_ctrl #(.PULSE_W(2)) dut (
    .clk        (clk),
    .rst        (rst),
    .cmd_valid  (cmd_valid),
    .cmd_op     (cmd_op),
    .cmd_arg    (cmd_arg),
    .cmd_ready  (cmd_ready),
    .halt_req   (halt_req),
    .pc         (pc),
    .clk_cpu    (clk_cpu),
    .busy       (busy),
    .done       (done),
    .stop_cause (stop_cause),
    .cycle_cnt  (cycle_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Presents one command for a single rising edge; called at a falling edge.
  task automatic issue(input logic [1:0] op, input logic [31:0] arg);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_arg   = arg;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
  endtask

  // Samples each falling edge until the DUT is idle again. pc walks 0x10..0x1C
  // after each pulse when walk_pc is set; halt_req rises in the HI of pulse
  // halt_pulse (0 = never); poke keeps a command offered while busy.
  task automatic watch(input bit walk_pc, input int halt_pulse, input bit poke,
                       output int n_pulse, output int n_hi, output logic [31:0] shape);
    logic prev;
    bit   fin;
    prev    = 1'b0;
    fin     = 1'b0;
    n_pulse = 0;
    n_hi    = 0;
    shape   = '0;
    for (int i = 0; i < 400 && !fin; i++) begin
      @(negedge clk);
      if (!busy) begin
        check("done_pulse", done, 1'b1);
        check("ready_idle", cmd_ready, 1'b1);
        fin = 1'b1;
      end else begin
        if (i == 0) check("ready_busy", cmd_ready, 1'b0);
        if (poke) begin
          cmd_valid = 1'b1;
          cmd_op    = OP_STEP;
          cmd_arg   = 32'd1;
        end
        shape = {shape[30:0], clk_cpu};
        if (clk_cpu) n_hi++;
        if (clk_cpu && !prev) begin
          n_pulse++;
          if (n_pulse == halt_pulse) halt_req = 1'b1;
        end
        if (walk_pc && prev && !clk_cpu) pc = (pc == 32'h1C) ? 32'h10 : pc + 32'd4;
        prev = clk_cpu;
      end
    end
    if (!fin) check("timeout", 1'b1, 1'b0);
    cmd_valid = 1'b0;
    halt_req  = 1'b0;
    @(negedge clk);
    check("done_once", done, 1'b0);
  endtask

  initial begin
    bit hit;
    rst       = 1'b1;
    cmd_valid = 1'b0;
    cmd_op    = OP_STEP;
    cmd_arg   = '0;
    halt_req  = 1'b0;
    pc        = 32'h0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("rst_ready", cmd_ready, 1'b1);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_clk", clk_cpu, 1'b0);
    check("rst_cause", stop_cause, 2'd0);
    check("rst_cnt", cycle_cnt, 32'd0);

    // STEP 3: three 1100 pulses, done right after the 12th pulse cycle.
    issue(OP_STEP, 32'd3);
    watch(1'b0, 0, 1'b0, pulses, hi_n, pat);
    check("step3_shape", pat, 32'hCCC);
    check("step3_pulses", pulses, 32'd3);
    check("step3_cause", stop_cause, 2'd1);
    check("step3_cnt", cycle_cnt, 32'd3);

    // STEP 0 behaves as STEP 1.
    @(negedge clk);
    issue(OP_STEP, 32'd0);
    watch(1'b0, 0, 1'b0, pulses, hi_n, pat);
    check("step0_pulses", pulses, 32'd1);
    check("step0_cause", stop_cause, 2'd1);
    check("step0_cnt", cycle_cnt, 32'd4);

    // SETBP stays idle with no pulse.
    @(negedge clk);
    issue(OP_SETBP, 32'h10);
    @(negedge clk);
    check("setbp_idle", busy, 1'b0);
    check("setbp_clk", clk_cpu, 1'b0);
    check("setbp_cnt", cycle_cnt, 32'd4);

    // RUN from the breakpoint: steps off it, stops when pc comes back around.
    pc = 32'h10;
    issue(OP_RUN, 32'd0);
    watch(1'b1, 0, 1'b0, pulses, hi_n, pat);
    check("bp_pulses", pulses, 32'd4);
    check("bp_cause", stop_cause, 2'd2);
    check("bp_cnt", cycle_cnt, 32'd8);

    // Breakpoint and halt on the same boundary: breakpoint wins.
    @(negedge clk);
    pc = 32'h10;
    issue(OP_RUN, 32'd0);
    watch(1'b0, 1, 1'b0, pulses, hi_n, pat);
    check("both_pulses", pulses, 32'd1);
    check("both_cause", stop_cause, 2'd2);
    check("both_cnt", cycle_cnt, 32'd9);

    // Halt raised mid-HI of pulse 5 with breakpoint cleared; offered commands ignored.
    @(negedge clk);
    issue(OP_CLRBP, 32'd0);
    @(negedge clk);
    issue(OP_RUN, 32'd0);
    watch(1'b0, 5, 1'b1, pulses, hi_n, pat);
    check("halt_pulses", pulses, 32'd5);
    check("halt_hi_cycles", hi_n, 32'd10);
    check("halt_tail", pat[3:0], 4'b1100);
    check("halt_cause", stop_cause, 2'd3);
    check("halt_cnt", cycle_cnt, 32'd14);

    // halt_req is ignored in STEP mode.
    @(negedge clk);
    issue(OP_STEP, 32'd2);
    watch(1'b0, 1, 1'b0, pulses, hi_n, pat);
    check("stephalt_pulses", pulses, 32'd2);
    check("stephalt_cause", stop_cause, 2'd1);
    check("stephalt_cnt", cycle_cnt, 32'd16);

    // Reset during HI clears everything including the breakpoint.
    @(negedge clk);
    issue(OP_SETBP, 32'h10);
    @(negedge clk);
    issue(OP_RUN, 32'd0);
    hit = 1'b0;
    for (int i = 0; i < 20 && !hit; i++) begin
      @(negedge clk);
      if (clk_cpu) hit = 1'b1;
    end
    if (!hit) check("rst_hi_seen", 1'b0, 1'b1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rstmid_clk", clk_cpu, 1'b0);
    check("rstmid_busy", busy, 1'b0);
    check("rstmid_ready", cmd_ready, 1'b1);
    check("rstmid_done", done, 1'b0);
    check("rstmid_cause", stop_cause, 2'd0);
    check("rstmid_cnt", cycle_cnt, 32'd0);
    issue(OP_RUN, 32'd0);
    watch(1'b0, 3, 1'b0, pulses, hi_n, pat);
    check("postrst_pulses", pulses, 32'd3);
    check("postrst_cause", stop_cause, 2'd3);
    check("postrst_cnt", cycle_cnt, 32'd3);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
